// File: rtl/fifo_serial_tx.sv
// Serial transmitter that pops bytes from a FIFO read port and sends them as
// 8-N-1 frames (optionally 8-E-1), LSB first, with the line idling high.
module fifo_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    input  logic       tx_en,
    output logic       rd,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned      CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             parity_q,  parity_d;

    logic bit_end;
    logic can_pop;

    assign bit_end = (cnt_q == CNT_LAST);
    assign can_pop = tx_en && !fifo_empty;

    // NOTE: reset clears every register asynchronously, including the shift
    // register, so a byte in flight is dropped and never re-sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        rd        = 1'b0;
        tx_serial = 1'b1;
        tx_busy   = 1'b1;
        tx_done   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tx_busy = 1'b0;
                cnt_d   = '0;
                if (can_pop) begin
                    state_d = S_POP;
                end
            end

            S_POP: begin
                rd        = 1'b1;
                shift_d   = fifo_data;
                parity_d  = ^fifo_data;
                cnt_d     = '0;
                bit_idx_d = '0;
                state_d   = S_START;
            end

            S_START: begin
                tx_serial = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                tx_serial = shift_q[0];
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_PARITY: begin
                tx_serial = parity_q;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                tx_done = bit_end;
                if (bit_end) begin
                    cnt_d   = '0;
                    // The next pop decision is taken only here, so a FIFO write
                    // or tx_en change mid-frame never disturbs the current byte.
                    state_d = can_pop ? S_POP : S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
